ajuste_param: RTL

AJUSTE_PARAM -- requirements
Module: ajuste_param

---
 rtl/ajuste_param_pkg.sv | 15 +
 rtl/ajuste_sat.sv | 33 +++
 rtl/ajuste_param.sv | 124 ++++++++++++
 3 files changed

// File: rtl/ajuste_param_pkg.sv
// Shared constants for the ajuste_param rescaler: default widths and the
// rounding-mode encoding carried on rnd_en.
package ajuste_param_pkg;

  localparam int IN_W_DEF  = 60;
  localparam int OUT_W_DEF = 18;
  localparam int SH_W_DEF  = 6;
  localparam int CNT_W_DEF = 16;

  typedef enum logic {
    RND_TRUNC   = 1'b0,
    RND_HALF_UP = 1'b1
  } rnd_mode_e;

endpackage

// File: rtl/ajuste_sat.sv
// Combinational range check of the shifted value against the signed OUT_W
// range, followed by saturate or wrap; an illegal shift forces a zero result.
module ajuste_sat
  import ajuste_param_pkg::*;
#(
  parameter int IN_W  = IN_W_DEF,
  parameter int OUT_W = OUT_W_DEF
) (
  input  logic signed [IN_W:0]  val,
  input  logic                  sat_en,
  input  logic                  err,
  output logic [OUT_W-1:0]      y,
  output logic                  ovf
);

  // The value fits when every bit above the OUT_W sign bit copies that sign bit.
  logic fits;
  assign fits = (val[IN_W:OUT_W-1] == {(IN_W-OUT_W+2){val[OUT_W-1]}});

  always_comb begin
    ovf = 1'b0;
    y   = val[OUT_W-1:0];
    if (err) begin
      y = '0;
    end else begin
      ovf = !fits;
      if (!fits && sat_en) begin
        y = val[IN_W] ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};
      end
    end
  end

endmodule

// File: rtl/ajuste_param.sv
// Two-stage valid/ready rescaler: S1 rounds and arithmetic-shifts the raw
// product, S2 range-checks, saturates or wraps, and counts saturation events.
module ajuste_param
  import ajuste_param_pkg::*;
#(
  parameter int IN_W  = IN_W_DEF,
  parameter int OUT_W = OUT_W_DEF,
  parameter int SH_W  = SH_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  r,
  input  logic [SH_W-1:0]  s,
  input  logic             rnd_en,
  input  logic             sat_en,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] y,
  output logic             ovf,
  output logic             err,
  input  logic             sat_clr,
  output logic [CNT_W-1:0] sat_cnt
);

  // Handshake: a word moves across an interface on a cycle where valid and
  // ready are both high; valid never depends on ready, and in_ready depends
  // only on stage occupancy and out_ready, never on in_valid.

  localparam int              MAX_S   = IN_W - OUT_W;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic                s1_valid;
  logic signed [IN_W:0] s1_val;
  logic                s1_sat_en;
  logic                s1_err;
  logic                s2_sat_en;
  logic                s2_load;

  logic                 s_err;
  rnd_mode_e            rnd_mode;
  logic signed [IN_W:0] rnd_add;
  logic signed [IN_W:0] sum;
  logic signed [IN_W:0] shifted;
  logic [OUT_W-1:0]     sat_y;
  logic                 sat_ovf;

  assign s2_load  = !out_valid || out_ready;
  assign in_ready = !s1_valid || s2_load;

  assign s_err    = (int'(s) > MAX_S);
  assign rnd_mode = rnd_mode_e'(rnd_en);

  // One extra bit of headroom keeps the half-up add from ever wrapping.
  always_comb begin
    rnd_add = '0;
    if (rnd_mode == RND_HALF_UP && s != '0 && !s_err) begin
      rnd_add = (IN_W+1)'(1) << (s - 1'b1);
    end
    sum     = $signed({r[IN_W-1], r}) + rnd_add;
    shifted = sum >>> s;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s1_val    <= '0;
      s1_sat_en <= 1'b0;
      s1_err    <= 1'b0;
    end else begin
      if (in_ready) begin
        s1_valid <= in_valid;
      end
      if (in_ready && in_valid) begin
        s1_val    <= shifted;
        s1_sat_en <= sat_en;
        s1_err    <= s_err;
      end
    end
  end

  ajuste_sat #(
    .IN_W  (IN_W),
    .OUT_W (OUT_W)
  ) u_sat (
    .val    (s1_val),
    .sat_en (s1_sat_en),
    .err    (s1_err),
    .y      (sat_y),
    .ovf    (sat_ovf)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      y         <= '0;
      ovf       <= 1'b0;
      err       <= 1'b0;
      s2_sat_en <= 1'b0;
    end else if (s2_load) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        y         <= sat_y;
        ovf       <= sat_ovf;
        err       <= s1_err;
        s2_sat_en <= s1_sat_en;
      end
    end
  end

  // Clear wins over a coincident saturation event; the count sticks at all-ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sat_cnt <= '0;
    end else if (sat_clr) begin
      sat_cnt <= '0;
    end else if (out_valid && out_ready && ovf && s2_sat_en && sat_cnt != CNT_MAX) begin
      sat_cnt <= sat_cnt + 1'b1;
    end
  end

endmodule
